// File: rtl/lamp_ctrl.sv
// Timed stairwell lamp controller: any rising edge on S1/S2/S3 lights F for
// ON_CYCLES clocks, and a new press restarts the full on-time.
module lamp_ctrl #(
  parameter int CNT_WIDTH = 8,
  parameter int ON_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic S1,
  input  logic S2,
  input  logic S3,
  output logic F
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ON   = 1'b1;

  localparam logic [CNT_WIDTH-1:0] RELOAD   = CNT_WIDTH'(ON_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [2:0]           sw_s;
  logic [2:0]           meta_r;
  logic [2:0]           sync_r;
  logic [2:0]           prev_r;
  logic                 press_s;

  logic [0:0]           state_r;
  logic [0:0]           state_s;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] cnt_s;
  logic                 f_r;
  logic                 f_s;

  assign sw_s = {S3, S2, S1};

  // Simultaneous edges on several switches merge into a single press.
  assign press_s = |(sync_r & ~prev_r);

  // Two-flop synchroniser plus previous-value flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= 3'b000;
      sync_r <= 3'b000;
      prev_r <= 3'b000;
    end else begin
      meta_r <= sw_s;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  // Next-state logic: a press always wins, including on the expiry cycle.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    f_s     = f_r;
    if (press_s) begin
      state_s = ON;
      cnt_s   = RELOAD;
      f_s     = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          f_s     = 1'b0;
        end
        ON: begin
          if (cnt_r != CNT_ZERO) begin
            state_s = ON;
            cnt_s   = cnt_r - CNT_ONE;
            f_s     = 1'b1;
          end else begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
            f_s     = 1'b0;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          f_s     = 1'b0;
        end
      endcase
    end
  end

  // State, counter and lamp output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      f_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      f_r     <= f_s;
    end
  end

  assign F = f_r;

endmodule

// File: tb/tb_lamp_ctrl.sv
// Scoreboard bench for lamp_ctrl: stimulus queues expected F transitions and
// level probes by clock-edge index; a negedge monitor pops and compares them.
module tb_lamp_ctrl;

  typedef struct {
    int   cyc;
    logic val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic S1;
  logic S2;
  logic S3;
  logic F;

  int   cyc = 0;
  logic done = 1'b0;
  logic f_last = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ev_t ev_q[$];
  ev_t pr_q[$];

  lamp_ctrl #(.CNT_WIDTH(8), .ON_CYCLES(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .S1    (S1),
    .S2    (S2),
    .S3    (S3),
    .F     (F)
  );

  always #5 clk = ~clk;

  // Edge index: after the n-th rising edge cyc equals n.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void exp_ev(input int c, input logic v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    ev_q.push_back(e);
  endfunction

  function automatic void probe(input int c, input logic v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    pr_q.push_back(e);
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(input logic [2:0] m);
    {S3, S2, S1} = m;
    @(negedge clk);
    {S3, S2, S1} = 3'b000;
  endtask

  // Monitor: compares every F transition and every due probe against the queues.
  always @(negedge clk) begin
    ev_t e;
    if (F !== f_last) begin
      checks = checks + 1;
      if (ev_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL spurious_edge: F went %b at cycle %0d, none expected", F, cyc);
      end else begin
        e = ev_q.pop_front();
        if (e.cyc != cyc || e.val !== F) begin
          failures = failures + 1;
          $display("FAIL edge: F went %b at cycle %0d, expected %b at cycle %0d",
                   F, cyc, e.val, e.cyc);
        end
      end
    end
    f_last = F;
    while (pr_q.size() > 0 && pr_q[0].cyc <= cyc) begin
      e = pr_q.pop_front();
      checks = checks + 1;
      if (e.cyc != cyc) begin
        failures = failures + 1;
        $display("FAIL probe_missed: probe at cycle %0d seen at cycle %0d", e.cyc, cyc);
      end else if (F !== e.val) begin
        failures = failures + 1;
        $display("FAIL level: F=%b at cycle %0d, expected %b", F, cyc, e.val);
      end
    end
    if (done) begin
      checks = checks + 1;
      if (ev_q.size() != 0) begin
        failures = failures + 1;
        $display("FAIL missing_edges: %0d expected transitions never seen, next at cycle %0d",
                 ev_q.size(), ev_q[0].cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    int k;
    int k2;
    int c;
    rst_n = 1'b0;
    {S3, S2, S1} = 3'b000;
    probe(2, 1'b0);
    probe(4, 1'b0);

    // Test 1: reset then 100 idle cycles.
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    probe(cyc + 1, 1'b0);
    probe(cyc + 50, 1'b0);
    probe(cyc + 100, 1'b0);
    wait_until(cyc + 100);

    // Test 2: single S1 pulse sampled at edge k.
    k = cyc + 1;
    exp_ev(k + 2, 1'b1);
    exp_ev(k + 258, 1'b0);
    probe(k + 1, 1'b0);
    probe(k + 2, 1'b1);
    probe(k + 257, 1'b1);
    probe(k + 258, 1'b0);
    pulse(3'b001);

    // Test 3: S2 then S3, 300 cycles apart, independent pulses.
    wait_until(k + 299);
    k = cyc + 1;
    exp_ev(k + 2, 1'b1);
    exp_ev(k + 258, 1'b0);
    probe(k + 280, 1'b0);
    pulse(3'b010);
    wait_until(k + 299);
    k = cyc + 1;
    exp_ev(k + 2, 1'b1);
    exp_ev(k + 258, 1'b0);
    pulse(3'b100);

    // Test 4: S1 then S3 100 cycles later keeps F high continuously.
    wait_until(k + 300);
    k = cyc + 1;
    exp_ev(k + 2, 1'b1);
    exp_ev(k + 100 + 258, 1'b0);
    probe(k + 258, 1'b1);
    probe(k + 357, 1'b1);
    pulse(3'b001);
    wait_until(k + 99);
    pulse(3'b100);

    // Test 5a: all three switches in one cycle give one pulse.
    wait_until(k + 400);
    k = cyc + 1;
    exp_ev(k + 2, 1'b1);
    exp_ev(k + 258, 1'b0);
    pulse(3'b111);

    // Test 5b: S2 held for 600 cycles lights F for 256 cycles only.
    wait_until(k + 300);
    k = cyc + 1;
    exp_ev(k + 2, 1'b1);
    exp_ev(k + 258, 1'b0);
    probe(k + 400, 1'b0);
    probe(k + 599, 1'b0);
    S2 = 1'b1;
    wait_until(k + 599);
    S2 = 1'b0;

    // Test 6: reset mid-ON drops F at the reset edge, then a full pulse.
    wait_until(k + 620);
    k = cyc + 1;
    exp_ev(k + 2, 1'b1);
    pulse(3'b001);
    wait_until(k + 99);
    exp_ev(k + 100, 1'b0);
    probe(k + 101, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_until(k + 120);
    k = cyc + 1;
    exp_ev(k + 2, 1'b1);
    exp_ev(k + 258, 1'b0);
    pulse(3'b001);

    // Test 7: press landing exactly on the expiry edge extends F.
    wait_until(k + 300);
    k = cyc + 1;
    k2 = k + 256;
    exp_ev(k + 2, 1'b1);
    exp_ev(k2 + 258, 1'b0);
    probe(k + 258, 1'b1);
    pulse(3'b001);
    wait_until(k2 - 1);
    pulse(3'b010);

    // Test 8: press one edge after expiry gives a one-cycle gap.
    wait_until(k2 + 300);
    k = cyc + 1;
    k2 = k + 257;
    exp_ev(k + 2, 1'b1);
    exp_ev(k + 258, 1'b0);
    exp_ev(k2 + 2, 1'b1);
    exp_ev(k2 + 258, 1'b0);
    pulse(3'b100);
    wait_until(k2 - 1);
    pulse(3'b100);

    // Test 9: switch already high when reset is released counts as a press.
    wait_until(k2 + 300);
    S3 = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    c = cyc;
    rst_n = 1'b1;
    k = c + 1;
    exp_ev(k + 2, 1'b1);
    exp_ev(k + 258, 1'b0);
    probe(k + 1, 1'b0);
    wait_until(k + 10);
    S3 = 1'b0;

    wait_until(k + 280);
    done = 1'b1;
  end

endmodule
